// File: rtl/nios_sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker: FSM states,
// default expected image identity and the word map of the sysid slave.
package nios_sysid_pkg;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] ID_DEFAULT = 32'hE097CBDC;
    localparam logic [DATA_W-1:0] TS_DEFAULT = 32'h5767F2DA;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        WT_ID = 3'd2,
        RD_TS = 3'd3,
        WT_TS = 3'd4,
        DONE  = 3'd5
    } state_t;

    // States in which a read command is presented on the bus.
    function automatic logic is_read_state(input state_t s);
        return (s == RD_ID) || (s == RD_TS);
    endfunction

    // States belonging to the timestamp half of the check.
    function automatic logic is_ts_state(input state_t s);
        return (s == RD_TS) || (s == WT_TS);
    endfunction

endpackage

// File: rtl/nios_sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the
// system-ID control slave.
interface nios_sysid_checker_if;
    import nios_sysid_pkg::*;

    logic              avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );

endinterface

// File: rtl/nios_sysid_checker.sv
// Reads the system ID and build timestamp words on request and compares
// them with the expected image identity, with a per-state bus timeout.
module nios_sysid_checker
    import nios_sysid_pkg::*;
#(
    parameter logic [DATA_W-1:0] ID_EXPECTED    = ID_DEFAULT,
    parameter logic [DATA_W-1:0] TS_EXPECTED    = TS_DEFAULT,
    parameter int                TIMEOUT_CYCLES = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    nios_sysid_checker_if.master avm,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 id_ok,
    output logic                 ts_ok,
    output logic                 timeout_err,
    output logic [DATA_W-1:0]    id_value,
    output logic [DATA_W-1:0]    ts_value
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_id_ok;
    logic              r_ts_ok;
    logic              r_timeout_err;
    logic [DATA_W-1:0] r_id_value;
    logic [DATA_W-1:0] r_ts_value;

    logic              w_accept;
    logic              w_rvalid;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_expire;

    // Bus command is a pure decode of the registered state.
    assign avm.avm_read    = is_read_state(r_state);
    assign avm.avm_address = is_ts_state(r_state) ? ADDR_TS : ADDR_ID;

    assign w_accept  = avm.avm_read && !avm.avm_waitrequest;
    assign w_rvalid  = avm.avm_readdatavalid;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    // The counter reaching its limit ends the phase unless progress arrives
    // in the same cycle; progress is tested first so data wins.
    assign w_expire  = (w_cnt_inc == CNT_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_id_ok       <= 1'b0;
            r_ts_ok       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_id_value    <= '0;
            r_ts_value    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state       <= RD_ID;
                        r_busy        <= 1'b1;
                        r_cnt         <= '0;
                        r_id_ok       <= 1'b0;
                        r_ts_ok       <= 1'b0;
                        r_timeout_err <= 1'b0;
                        r_id_value    <= '0;
                        r_ts_value    <= '0;
                    end
                end
                RD_ID, RD_TS: begin
                    if (w_accept) begin
                        r_state <= (r_state == RD_ID) ? WT_ID : WT_TS;
                        r_cnt   <= '0;
                    end else if (w_expire) begin
                        r_state       <= DONE;
                        r_done        <= 1'b1;
                        r_cnt         <= '0;
                        r_timeout_err <= 1'b1;
                        r_id_ok       <= 1'b0;
                        r_ts_ok       <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                WT_ID: begin
                    if (w_rvalid) begin
                        r_state    <= RD_TS;
                        r_cnt      <= '0;
                        r_id_value <= avm.avm_readdata;
                        r_id_ok    <= (avm.avm_readdata == ID_EXPECTED);
                    end else if (w_expire) begin
                        r_state       <= DONE;
                        r_done        <= 1'b1;
                        r_cnt         <= '0;
                        r_timeout_err <= 1'b1;
                        r_id_ok       <= 1'b0;
                        r_ts_ok       <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                WT_TS: begin
                    if (w_rvalid) begin
                        r_state    <= DONE;
                        r_done     <= 1'b1;
                        r_cnt      <= '0;
                        r_ts_value <= avm.avm_readdata;
                        r_ts_ok    <= (avm.avm_readdata == TS_EXPECTED);
                    end else if (w_expire) begin
                        r_state       <= DONE;
                        r_done        <= 1'b1;
                        r_cnt         <= '0;
                        r_timeout_err <= 1'b1;
                        r_id_ok       <= 1'b0;
                        r_ts_ok       <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout_err = r_timeout_err;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_nios_sysid_checker.sv
// Directed bench for nios_sysid_checker with a configurable Avalon slave model.
module tb_nios_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'hE097CBDC;
    localparam logic [31:0] EXP_TS = 32'h5767F2DA;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, id_ok, ts_ok, timeout_err;
    logic [31:0] id_value, ts_value;

    always #5 clock = ~clock;

    nios_sysid_checker_if ifc ();

    nios_sysid_checker #(
        .ID_EXPECTED   (EXP_ID),
        .TS_EXPECTED   (EXP_TS),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .avm        (ifc.master),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .id_ok      (id_ok),
        .ts_ok      (ts_ok),
        .timeout_err(timeout_err),
        .id_value   (id_value),
        .ts_value   (ts_value)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slave configuration, written only by the main sequence.
    int          cfg_wait = 0;
    int          cfg_lat  = 1;
    logic [31:0] cfg_word0 = EXP_ID;
    logic [31:0] cfg_word1 = EXP_TS;
    logic [1:0]  cfg_rdv_en = 2'b11;
    int          cfg_gen = 0;
    logic        stray = 1'b0;

    task automatic set_slave(input int w, input int lat, input logic [31:0] w0,
                             input logic [31:0] w1, input logic [1:0] en);
        cfg_wait   = w;
        cfg_lat    = lat;
        cfg_word0  = w0;
        cfg_word1  = w1;
        cfg_rdv_en = en;
        cfg_gen++;
    endtask

    // Slave model: stalls each read cfg_wait cycles, answers cfg_lat cycles
    // after acceptance, and can inject one stray strobe.
    initial begin
        int   s_stall = 0;
        int   s_pcnt = 0;
        logic s_pend = 1'b0;
        logic s_paddr = 1'b0;
        logic s_acc_prev = 1'b0;
        logic s_addr_prev = 1'b0;
        int   s_gen = 0;
        ifc.avm_waitrequest   = 1'b0;
        ifc.avm_readdatavalid = 1'b0;
        ifc.avm_readdata      = '0;
        forever begin
            @(posedge clock);
            #1;
            if (s_gen != cfg_gen) begin
                s_gen = cfg_gen;
                s_stall = 0;
                s_pend = 1'b0;
                s_acc_prev = 1'b0;
            end
            if (s_acc_prev) begin
                s_pend  = 1'b1;
                s_pcnt  = cfg_lat - 1;
                s_paddr = s_addr_prev;
            end
            if (reset) s_pend = 1'b0;
            ifc.avm_readdatavalid = 1'b0;
            if (s_pend) begin
                if (s_pcnt == 0) begin
                    ifc.avm_readdatavalid = cfg_rdv_en[s_paddr];
                    ifc.avm_readdata      = s_paddr ? cfg_word1 : cfg_word0;
                    s_pend = 1'b0;
                end else begin
                    s_pcnt--;
                end
            end
            if (stray) begin
                ifc.avm_readdatavalid = 1'b1;
                ifc.avm_readdata      = 32'hDEADBEEF;
            end
            if (ifc.avm_read && (s_stall < cfg_wait)) begin
                ifc.avm_waitrequest = 1'b1;
                s_stall++;
            end else begin
                ifc.avm_waitrequest = 1'b0;
                if (ifc.avm_read) s_stall = 0;
            end
            s_acc_prev  = ifc.avm_read && !ifc.avm_waitrequest && !reset;
            s_addr_prev = ifc.avm_address;
        end
    end

    // Pulses start at the current falling edge and follows the check until done.
    task automatic run_check(input int extra_start, output int done_cyc,
                             output int busy_cyc, output int stall_err);
        logic prev_stall = 1'b0;
        logic prev_addr  = 1'b0;
        done_cyc  = -1;
        busy_cyc  = 0;
        stall_err = 0;
        start = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clock);
            start = (n == extra_start);
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc = n;
                break;
            end
            if (prev_stall && !(ifc.avm_read && ifc.avm_address == prev_addr)) stall_err++;
            prev_stall = ifc.avm_read && ifc.avm_waitrequest;
            prev_addr  = ifc.avm_address;
        end
        start = 1'b0;
    endtask

    task automatic expect_run(input string t, input int extra, input int e_done, input int e_busy,
                              input logic e_id_ok, input logic e_ts_ok, input logic e_to,
                              input logic [31:0] e_idv, input logic [31:0] e_tsv);
        int dc, bc, se;
        run_check(extra, dc, bc, se);
        chk({t, " done_cycle"}, dc, e_done);
        chk({t, " busy_cycles"}, bc, e_busy);
        chk({t, " read_stable"}, se, 0);
        chk({t, " id_ok"}, id_ok, e_id_ok);
        chk({t, " ts_ok"}, ts_ok, e_ts_ok);
        chk({t, " timeout_err"}, timeout_err, e_to);
        chk({t, " id_value"}, id_value, e_idv);
        chk({t, " ts_value"}, ts_value, e_tsv);
        chk({t, " read_at_done"}, ifc.avm_read, 1'b0);
        @(negedge clock);
        chk({t, " done_width"}, done, 1'b0);
        chk({t, " busy_after"}, busy, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst id_ok", id_ok, 1'b0);
        chk("rst ts_ok", ts_ok, 1'b0);
        chk("rst timeout_err", timeout_err, 1'b0);
        chk("rst id_value", id_value, 32'h0);
        chk("rst ts_value", ts_value, 32'h0);
        chk("rst avm_read", ifc.avm_read, 1'b0);
        chk("rst avm_address", ifc.avm_address, 1'b0);

        set_slave(0, 1, EXP_ID, EXP_TS, 2'b11);
        expect_run("nominal", 0, 5, 5, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);

        set_slave(0, 1, EXP_ID, 32'h5767F2DB, 2'b11);
        expect_run("ts_mismatch", 0, 5, 5, 1'b1, 1'b0, 1'b0, EXP_ID, 32'h5767F2DB);

        set_slave(0, 1, 32'hE097CBDD, EXP_TS, 2'b11);
        expect_run("id_mismatch", 0, 5, 5, 1'b0, 1'b1, 1'b0, 32'hE097CBDD, EXP_TS);

        set_slave(3, 2, EXP_ID, EXP_TS, 2'b11);
        expect_run("stall", 0, 13, 13, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);

        set_slave(0, 1, EXP_ID, EXP_TS, 2'b10);
        expect_run("to_wait", 0, 9, 9, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

        set_slave(20, 1, EXP_ID, EXP_TS, 2'b11);
        expect_run("to_read", 0, 8, 8, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

        set_slave(0, 7, EXP_ID, EXP_TS, 2'b11);
        expect_run("edge_ok", 0, 17, 17, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);

        set_slave(0, 8, EXP_ID, EXP_TS, 2'b11);
        expect_run("edge_to", 0, 9, 9, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

        // Reset while waiting for the timestamp word.
        set_slave(0, 3, EXP_ID, EXP_TS, 2'b11);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        chk("mid id_value", id_value, EXP_ID);
        chk("mid avm_read", ifc.avm_read, 1'b0);
        chk("mid avm_address", ifc.avm_address, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mrst busy", busy, 1'b0);
        chk("mrst done", done, 1'b0);
        chk("mrst id_ok", id_ok, 1'b0);
        chk("mrst ts_ok", ts_ok, 1'b0);
        chk("mrst timeout_err", timeout_err, 1'b0);
        chk("mrst id_value", id_value, 32'h0);
        chk("mrst ts_value", ts_value, 32'h0);
        chk("mrst avm_read", ifc.avm_read, 1'b0);
        chk("mrst avm_address", ifc.avm_address, 1'b0);
        repeat (4) @(negedge clock);
        chk("mrst quiet busy", busy, 1'b0);

        // A second start while busy must neither disturb nor queue a run.
        set_slave(0, 1, EXP_ID, EXP_TS, 2'b11);
        expect_run("busy_start", 2, 5, 5, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("no_requeue busy", busy, 1'b0);
            chk("no_requeue read", ifc.avm_read, 1'b0);
        end

        // Stray response strobe in IDLE.
        stray = 1'b1;
        @(negedge clock);
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stray busy", busy, 1'b0);
            chk("stray done", done, 1'b0);
            chk("stray id_value", id_value, EXP_ID);
            chk("stray ts_value", ts_value, EXP_TS);
            chk("stray id_ok", id_ok, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/nios_sysid_checker.md
# nios_sysid_checker

Avalon-MM read master at the opposite end of the system-ID control slave. On a start pulse it reads word 0 (system ID) and word 1 (build timestamp), then compares both against parameterised expected values. It reports pass/fail per word and flags a bus timeout. It sits beside the Nios subsystem so boot logic and the camera pipeline can gate start-up on a matching FPGA image without CPU involvement.

## Interface
- ID_EXPECTED, 32'hE097CBDC, expected system ID (word 0)
- TS_EXPECTED, 32'h5767F2DA, expected build timestamp (word 1)
- TIMEOUT_CYCLES, 1024, maximum cycles per read phase, ≥ 2
- clock  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run a check; ignored while busy
- avm_address  out  1  word select, 0 = ID, 1 = timestamp
- avm_read  out  1  read request, held until accepted
- avm_waitrequest  in  1  slave stall; the read is accepted on avm_read && !avm_waitrequest
- avm_readdata  in  32  read data, valid with avm_readdatavalid
- avm_readdatavalid  in  1  read response strobe
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- id_ok  out  1  sticky result: word 0 == ID_EXPECTED
- ts_ok  out  1  sticky result: word 1 == TS_EXPECTED
- timeout_err  out  1  sticky result: the last check timed out
- id_value  out  32  captured word 0
- ts_value  out  32  captured word 1

## Operation
- States: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, DONE.
- IDLE
  - start → RD_ID.
  - On this transition, clear id_ok, ts_ok, timeout_err, id_value, ts_value and the timeout counter.
- RD_ID
  - avm_read = 1, avm_address = 0.
  - Accept → WT_ID.
- WT_ID
  - avm_read = 0.
  - avm_readdatavalid → capture id_value, set id_ok = (readdata == ID_EXPECTED), go to RD_TS.
- RD_TS / WT_TS: identical to RD_ID / WT_ID with avm_address = 1, capturing ts_value and ts_ok.
- DONE
  - done = 1 for exactly one cycle, then → IDLE.
  - Results hold until the next start.
- Timeout
  - One counter, cleared on every state change; it increments in RD_* and WT_* states.
  - Counter == TIMEOUT_CYCLES-1 without progress → set timeout_err, force id_ok = ts_ok = 0, go to DONE.
  - A timeout in RD_* drops avm_read the following cycle. This is a deliberate abandon.
- Ignored inputs
  - avm_readdatavalid outside WT_* is ignored as a protocol violation; no state change.
  - start while not IDLE is ignored; no queuing.
- Counter width: $clog2(TIMEOUT_CYCLES).

## Timing
- Reset values
  - State IDLE.
  - avm_read 0, avm_address 0.
  - busy 0, done 0.
  - id_ok 0, ts_ok 0, timeout_err 0.
  - id_value 0, ts_value 0.
  - Counter 0.
- Reset mid-transaction: takes effect on the next edge with the above values. avm_read drops immediately and no response is awaited.
- All outputs are registered; avm_read/avm_address are decoded from registered state only.
- Zero wait states, 1-cycle read latency. Start is sampled at edge 0:
  - read addr 0 in cycle 1
  - readdatavalid in cycle 2
  - read addr 1 in cycle 3
  - readdatavalid in cycle 4
  - done in cycle 5
- busy is high in cycles 1–5.
- Each waitrequest stall cycle or extra latency cycle adds one cycle.
- A response in the same cycle the counter hits its limit counts as success; data wins over timeout.

## Structure
- Package nios_sysid_pkg holds:
  - the state enum
  - default ID/timestamp constants
  - word-address constants ADDR_ID = 1'b0, ADDR_TS = 1'b1
- Single module, no sub-modules. The timeout counter is inline.

## Test plan
- Matching slave model, 0 wait states, latency 1: start → done in cycle 5, id_ok = ts_ok = 1, id_value = 32'hE097CBDC, ts_value = 32'h5767F2DA.
- Slave returns word 1 = 32'h5767F2DB: done with id_ok = 1, ts_ok = 0, timeout_err = 0.
- waitrequest held 3 cycles per read, latency 2: done in cycle 5+6+2 = 13, avm_read held stable throughout each stall, results pass.
- readdatavalid never asserted for word 0, TIMEOUT_CYCLES = 8: done with timeout_err = 1, id_ok = ts_ok = 0, busy high exactly 9 cycles.
- Reset pulsed in WT_TS, then start pulsed in busy and a stray readdatavalid in IDLE: all outputs at reset values, the second start is ignored, and the stray strobe causes no state change.
